// File: rtl/nubus_pkg.sv
// NuBus target shared definitions: FSM states, ACK status codes, lane masks.
// No logic of its own; imported by the target and its decoder.
// Status codes are the {TM1*, TM0*} values driven during ACK.
package nubus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_MEM   = 3'd3,
        ST_ACK   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        STAT_COMPLETE = 2'b00,
        STAT_ERROR    = 2'b01,
        STAT_TIMEOUT  = 2'b10,
        STAT_TRYAGAIN = 2'b11
    } status_t;

    localparam logic [3:0] LANES_HALF_LO = 4'b0011;
    localparam logic [3:0] LANES_HALF_HI = 4'b1100;
    localparam logic [3:0] LANES_WORD    = 4'b1111;

    // One-hot strobe for a single byte transfer on lane a
    function automatic logic [3:0] byte_lane(input logic [1:0] a);
        return 4'b0001 << a;
    endfunction

endpackage

// File: rtl/nubus_target_decode.sv
// NuBus START decode: slot/superslot hit, byte-lane mask and direction.
// Purely combinational, zero latency.
// No flow control; the caller qualifies outputs with START and IDLE.
module nubus_target_decode
    import nubus_pkg::*;
#(
    parameter logic [3:0] SLOTS_ADDRESS = 4'hF
) (
    input  logic [7:0] ad_top_i,   // true-polarity ad[31:24]
    input  logic [1:0] ad_low_i,   // true-polarity ad[1:0]
    input  logic [3:0] idn_i,      // slot ID, active-low
    input  logic       tm1n_i,
    input  logic       tm0n_i,
    output logic       hit_o,
    output logic [3:0] lanes_o,
    output logic       write_o
);

    logic [3:0] slot_id;
    assign slot_id = ~idn_i;

    // Standard slot space (Fs.xxxxx) or this card's superslot (sxxxxxxx)
    assign hit_o = ((ad_top_i[7:4] == SLOTS_ADDRESS) && (ad_top_i[3:0] == slot_id))
                 || (ad_top_i[7:4] == slot_id);

    // TM1* low at START marks a write
    assign write_o = ~tm1n_i;

    // TM0* high selects a byte; otherwise ad[1:0] picks half-word or word
    always_comb begin
        lanes_o = LANES_WORD;
        if (tm0n_i) begin
            lanes_o = byte_lane(ad_low_i);
        end else begin
            case (ad_low_i)
                2'b00:   lanes_o = LANES_HALF_LO;
                2'b10:   lanes_o = LANES_HALF_HI;
                default: lanes_o = LANES_WORD;
            endcase
        end
    end

endmodule

// File: rtl/nubus_target.sv
// NuBus slave bridging bus cycles to a simple local memory request port.
// START->ACK is 2+N clocks for reads, 3+N for writes (N = memory wait clocks).
// Memory stalls extend MEM until ready/error/tryagain or the watchdog aborts.
module nubus_target
    import nubus_pkg::*;
#(
    parameter logic [3:0] SLOTS_ADDRESS = 4'hF,
    parameter int         WDT_W         = 8
) (
    input  logic        nub_clkn,
    input  logic        nub_reset,
    input  logic [3:0]  nub_idn,
    input  logic        nub_startn,
    input  logic        nub_tm1n_i,
    input  logic        nub_tm0n_i,
    input  logic [31:0] nub_adn_i,
    output logic        nub_ackn_o,
    output logic        nub_ack_oe,
    output logic        nub_tm1n_o,
    output logic        nub_tm0n_o,
    output logic        nub_tm_oe,
    output logic [31:0] nub_adn_o,
    output logic        nub_ad_oe,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        mem_error,
    input  logic        mem_tryagain,
    output logic        tgt_busy
);

    localparam logic [WDT_W-1:0] WDT_MAX = '1;
    localparam logic [WDT_W-1:0] WDT_ONE = {{(WDT_W-1){1'b0}}, 1'b1};

    logic [31:0]      ad;
    logic             dec_hit;
    logic [3:0]       dec_lanes;
    logic             dec_write;

    state_t           state_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       lanes_q;
    logic             write_q;
    logic             valid_q;
    logic [3:0]       mem_write_q;
    logic [WDT_W-1:0] wdt_q;
    logic [WDT_W-1:0] wdt_d;
    logic             ack_oe_q;
    logic             ackn_q;
    logic             tm_oe_q;
    logic             tm1n_q;
    logic             tm0n_q;
    logic             ad_oe_q;
    logic [31:0]      adn_q;
    logic             rsp_done;
    status_t          rsp_st;

    assign ad = ~nub_adn_i;

    nubus_target_decode #(
        .SLOTS_ADDRESS (SLOTS_ADDRESS)
    ) u_decode (
        .ad_top_i (ad[31:24]),
        .ad_low_i (ad[1:0]),
        .idn_i    (nub_idn),
        .tm1n_i   (nub_tm1n_i),
        .tm0n_i   (nub_tm0n_i),
        .hit_o    (dec_hit),
        .lanes_o  (dec_lanes),
        .write_o  (dec_write)
    );

    // Watchdog expires on the clock its count would reach all ones
    assign wdt_d = wdt_q + WDT_ONE;

    // Pick the MEM exit status: error beats tryagain beats ready beats timeout
    always_comb begin
        rsp_done = 1'b1;
        rsp_st   = STAT_COMPLETE;
        if (mem_error) begin
            rsp_st = STAT_ERROR;
        end else if (mem_tryagain) begin
            rsp_st = STAT_TRYAGAIN;
        end else if (mem_ready) begin
            rsp_st = STAT_COMPLETE;
        end else if (wdt_d == WDT_MAX) begin
            rsp_st = STAT_TIMEOUT;
        end else begin
            rsp_done = 1'b0;
        end
    end

    // Transfer FSM with registered bus and memory outputs
    always_ff @(posedge nub_clkn or posedge nub_reset) begin
        if (nub_reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            lanes_q     <= '0;
            write_q     <= 1'b0;
            valid_q     <= 1'b0;
            mem_write_q <= '0;
            wdt_q       <= '0;
            ack_oe_q    <= 1'b0;
            ackn_q      <= 1'b1;
            tm_oe_q     <= 1'b0;
            tm1n_q      <= 1'b1;
            tm0n_q      <= 1'b1;
            ad_oe_q     <= 1'b0;
            adn_q       <= '1;
        end else begin
            // Bus drivers are released everywhere except the single ACK clock
            ack_oe_q <= 1'b0;
            ackn_q   <= 1'b1;
            tm_oe_q  <= 1'b0;
            tm1n_q   <= 1'b1;
            tm0n_q   <= 1'b1;
            ad_oe_q  <= 1'b0;
            adn_q    <= '1;
            case (state_q)
                ST_IDLE: begin
                    if (!nub_startn && dec_hit) begin
                        addr_q  <= {ad[31:2], 2'b00};
                        lanes_q <= dec_lanes;
                        write_q <= dec_write;
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (write_q) begin
                        // Write data is on the bus the clock after START
                        wdata_q <= ad;
                        state_q <= ST_WDATA;
                    end else begin
                        valid_q <= 1'b1;
                        wdt_q   <= '0;
                        state_q <= ST_MEM;
                    end
                end
                ST_WDATA: begin
                    valid_q     <= 1'b1;
                    mem_write_q <= lanes_q;
                    wdt_q       <= '0;
                    state_q     <= ST_MEM;
                end
                ST_MEM: begin
                    wdt_q <= wdt_d;
                    if (rsp_done) begin
                        valid_q            <= 1'b0;
                        mem_write_q        <= '0;
                        ack_oe_q           <= 1'b1;
                        ackn_q             <= 1'b0;
                        tm_oe_q            <= 1'b1;
                        {tm1n_q, tm0n_q}   <= rsp_st;
                        if (!write_q && (rsp_st == STAT_COMPLETE)) begin
                            ad_oe_q <= 1'b1;
                            adn_q   <= ~mem_rdata;
                        end
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign nub_ackn_o = ackn_q;
    assign nub_ack_oe = ack_oe_q;
    assign nub_tm1n_o = tm1n_q;
    assign nub_tm0n_o = tm0n_q;
    assign nub_tm_oe  = tm_oe_q;
    assign nub_adn_o  = adn_q;
    assign nub_ad_oe  = ad_oe_q;
    assign mem_valid  = valid_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_write  = mem_write_q;
    assign tgt_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nubus_target.sv
// Bench for nubus_target: table of bus transfers plus miss, busy-START and mid-transfer reset.
// Expected memory requests and ACKs are queued at START and checked by a monitor.
// Memory responder stalls each request by a per-transfer wait count.
module tb_nubus_target;

    localparam int         WDT_W  = 4;
    localparam logic [2:0] R_NONE = 3'b000;
    localparam logic [2:0] R_RDY  = 3'b001;
    localparam logic [2:0] R_TRY  = 3'b010;
    localparam logic [2:0] R_ERR  = 3'b100;

    logic        nub_clkn;
    logic        nub_reset;
    logic [3:0]  nub_idn;
    logic        nub_startn;
    logic        nub_tm1n_i;
    logic        nub_tm0n_i;
    logic [31:0] nub_adn_i;
    logic        nub_ackn_o;
    logic        nub_ack_oe;
    logic        nub_tm1n_o;
    logic        nub_tm0n_o;
    logic        nub_tm_oe;
    logic [31:0] nub_adn_o;
    logic        nub_ad_oe;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_write;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_error;
    logic        mem_tryagain;
    logic        tgt_busy;

    nubus_target #(
        .SLOTS_ADDRESS (4'hF),
        .WDT_W         (WDT_W)
    ) dut (
        .nub_clkn     (nub_clkn),
        .nub_reset    (nub_reset),
        .nub_idn      (nub_idn),
        .nub_startn   (nub_startn),
        .nub_tm1n_i   (nub_tm1n_i),
        .nub_tm0n_i   (nub_tm0n_i),
        .nub_adn_i    (nub_adn_i),
        .nub_ackn_o   (nub_ackn_o),
        .nub_ack_oe   (nub_ack_oe),
        .nub_tm1n_o   (nub_tm1n_o),
        .nub_tm0n_o   (nub_tm0n_o),
        .nub_tm_oe    (nub_tm_oe),
        .nub_adn_o    (nub_adn_o),
        .nub_ad_oe    (nub_ad_oe),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .mem_error    (mem_error),
        .mem_tryagain (mem_tryagain),
        .tgt_busy     (tgt_busy)
    );

    typedef struct {
        logic [31:0] ad;
        logic        tm1n;
        logic        tm0n;
        logic [31:0] data;     // write data, or read data returned by memory
        int          wt;       // memory wait clocks
        logic [2:0]  resp;     // {error, tryagain, ready}
        logic [31:0] e_addr;
        logic [3:0]  e_wr;
        logic [1:0]  e_st;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wr;
        logic [31:0] wdata;
        logic [1:0]  st;
        logic        ad_oe;
        logic [31:0] adn;
        int          ack_cyc;
    } exp_t;

    exp_t        exp_q[$];
    vec_t        vecs[17];
    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          ack_count = 0;
    int          exp_acks  = 0;
    int          cur_wait  = 0;
    int          mem_cnt   = 0;
    logic [2:0]  cur_resp  = R_NONE;
    logic [31:0] cur_rdata = '0;
    logic        prev_ack  = 1'b0;
    logic        prev_vld  = 1'b0;

    assign mem_rdata = cur_rdata;

    initial nub_clkn = 1'b0;
    always #5 nub_clkn = ~nub_clkn;

    always @(posedge nub_clkn) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge nub_clkn);
        #1;
    endtask

    // Memory responder: answers once the request has waited cur_wait clocks
    always @(posedge nub_clkn) begin
        #1;
        if (mem_valid && !nub_reset) begin
            if (mem_cnt >= cur_wait) {mem_error, mem_tryagain, mem_ready} = cur_resp;
            else                     {mem_error, mem_tryagain, mem_ready} = 3'b000;
            mem_cnt++;
        end else begin
            mem_cnt = 0;
            {mem_error, mem_tryagain, mem_ready} = 3'b000;
        end
    end

    // Monitor: memory request and ACK against the queued expectations
    always @(posedge nub_clkn) begin
        exp_t e;
        #1;
        if (!nub_reset) begin
            if (prev_ack)
                chk("post_ack_quiet", {28'd0, nub_ack_oe, nub_tm_oe, nub_ad_oe, mem_valid}, 32'd0);
            if (!nub_ack_oe)
                chk("oe_outside_ack", {30'd0, nub_tm_oe, nub_ad_oe}, 32'd0);
            if (mem_valid && !prev_vld) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_mem_req", {31'd0, mem_valid}, 32'd0);
                end else begin
                    e = exp_q[0];
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_write", {28'd0, mem_write}, {28'd0, e.wr});
                    if (e.wr != 4'd0) chk("mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (nub_ack_oe) begin
                ack_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", {31'd0, nub_ack_oe}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_status", {30'd0, nub_tm1n_o, nub_tm0n_o}, {30'd0, e.st});
                    chk("ack_drive", {30'd0, nub_ackn_o, nub_tm_oe}, 32'd1);
                    chk("ack_ad_oe", {31'd0, nub_ad_oe}, {31'd0, e.ad_oe});
                    chk("ack_adn", nub_adn_o, e.adn);
                    chk("ack_latency", cyc, e.ack_cyc);
                end
            end
        end
        prev_ack = nub_reset ? 1'b0 : nub_ack_oe;
        prev_vld = nub_reset ? 1'b0 : mem_valid;
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_oe"}, {29'd0, nub_ack_oe, nub_tm_oe, nub_ad_oe}, 32'd0);
        chk({tag, "_ack_tm"}, {29'd0, nub_ackn_o, nub_tm1n_o, nub_tm0n_o}, 32'd7);
        chk({tag, "_adn"}, nub_adn_o, 32'hFFFF_FFFF);
        chk({tag, "_mem_vw"}, {27'd0, mem_valid, mem_write}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_busy"}, {31'd0, tgt_busy}, 32'd0);
    endtask

    task automatic bus_idle();
        nub_startn = 1'b1;
        nub_tm1n_i = 1'b1;
        nub_tm0n_i = 1'b1;
        nub_adn_i  = '1;
    endtask

    // Drive START for one clock; returns just after the sampling edge
    task automatic start_pulse(input logic [31:0] ad, input logic tm1n, input logic tm0n);
        nub_adn_i  = ~ad;
        nub_tm1n_i = tm1n;
        nub_tm0n_i = tm0n;
        nub_startn = 1'b0;
        tick();
        bus_idle();
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!nub_ack_oe && n < 40) begin
            tick();
            n++;
        end
        if (!nub_ack_oe) begin
            chk("ack_arrival", {31'd0, nub_ack_oe}, 32'd1);
            exp_q.delete();
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!mem_valid && n < 10) begin
            tick();
            n++;
        end
        if (!mem_valid) chk("mem_valid_arrival", {31'd0, mem_valid}, 32'd1);
    endtask

    task automatic push_exp(input vec_t v, input int lat);
        exp_t e;
        bit   wr;
        wr        = !v.tm1n;
        e.addr    = v.e_addr;
        e.wr      = wr ? v.e_wr : 4'd0;
        e.wdata   = v.data;
        e.st      = v.e_st;
        e.ad_oe   = !wr && (v.e_st == 2'b00);
        e.adn     = e.ad_oe ? ~v.data : 32'hFFFF_FFFF;
        e.ack_cyc = cyc + lat;
        exp_q.push_back(e);
    endtask

    // Full transfer; leaves the bench in the first IDLE clock after ACK
    task automatic run_txn(input vec_t v);
        bit wr;
        int lat;
        wr        = !v.tm1n;
        cur_wait  = v.wt;
        cur_resp  = v.resp;
        cur_rdata = v.data;
        // Timeout ACK lands 2^WDT_W-1 clocks after MEM entry, i.e. N = 2^WDT_W-2
        lat = (wr ? 3 : 2) + ((v.resp == R_NONE) ? ((1 << WDT_W) - 2) : v.wt);
        start_pulse(v.ad, v.tm1n, v.tm0n);
        push_exp(v, lat);
        exp_acks++;
        if (wr) begin
            nub_adn_i = ~v.data;
            tick();
            nub_adn_i = '1;
        end
        wait_ack();
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int  base;
        bit  seen;
        vec_t v;

        //          ad            tm1n  tm0n  data          wt resp          e_addr        e_wr     e_st
        vecs[0]  = '{32'hF900_0010, 1'b1, 1'b0, 32'h3C5A_0FF1, 0, R_RDY,         32'hF900_0010, 4'b0000, 2'b00};
        vecs[1]  = '{32'h9000_0003, 1'b0, 1'b1, 32'hAABB_CCDD, 0, R_RDY,         32'h9000_0000, 4'b1000, 2'b00};
        vecs[2]  = '{32'hF900_0100, 1'b0, 1'b0, 32'h1122_3344, 2, R_RDY,         32'hF900_0100, 4'b0011, 2'b00};
        vecs[3]  = '{32'hF900_0102, 1'b0, 1'b0, 32'h5566_7788, 1, R_RDY,         32'hF900_0100, 4'b1100, 2'b00};
        vecs[4]  = '{32'h9123_4561, 1'b0, 1'b0, 32'h99AA_BBCC, 0, R_RDY,         32'h9123_4560, 4'b1111, 2'b00};
        vecs[5]  = '{32'hF9AB_CDEF, 1'b0, 1'b0, 32'h0F0F_0F0F, 0, R_RDY,         32'hF9AB_CDEC, 4'b1111, 2'b00};
        vecs[6]  = '{32'h9000_0000, 1'b0, 1'b1, 32'h1357_9BDF, 3, R_RDY,         32'h9000_0000, 4'b0001, 2'b00};
        vecs[7]  = '{32'h9FFF_FFF5, 1'b0, 1'b1, 32'h2468_ACE0, 0, R_RDY,         32'h9FFF_FFF4, 4'b0010, 2'b00};
        vecs[8]  = '{32'hF9FF_FFFE, 1'b0, 1'b1, 32'hFEDC_BA98, 0, R_RDY,         32'hF9FF_FFFC, 4'b0100, 2'b00};
        vecs[9]  = '{32'hF900_2000, 1'b1, 1'b0, 32'h8000_0001, 5, R_RDY,         32'hF900_2000, 4'b0000, 2'b00};
        vecs[10] = '{32'h9000_0040, 1'b1, 1'b0, 32'h0000_1111, 3, R_TRY,         32'h9000_0040, 4'b0000, 2'b11};
        vecs[11] = '{32'h9000_0044, 1'b1, 1'b0, 32'h0000_2222, 0, R_ERR,         32'h9000_0044, 4'b0000, 2'b01};
        vecs[12] = '{32'h9000_0048, 1'b1, 1'b0, 32'h0000_3333, 1, R_ERR | R_RDY, 32'h9000_0048, 4'b0000, 2'b01};
        vecs[13] = '{32'h9000_004C, 1'b1, 1'b0, 32'h0000_4444, 0, R_TRY | R_RDY, 32'h9000_004C, 4'b0000, 2'b11};
        vecs[14] = '{32'hF900_0050, 1'b0, 1'b0, 32'h0000_5555, 2, R_ERR | R_TRY, 32'hF900_0050, 4'b0011, 2'b01};
        vecs[15] = '{32'h9000_0060, 1'b1, 1'b0, 32'h0000_6666, 0, R_NONE,        32'h9000_0060, 4'b0000, 2'b10};
        vecs[16] = '{32'h9000_0070, 1'b0, 1'b1, 32'h0000_7777, 0, R_NONE,        32'h9000_0070, 4'b0001, 2'b10};

        nub_idn   = ~4'h9;
        nub_reset = 1'b0;
        bus_idle();
        mem_ready    = 1'b0;
        mem_error    = 1'b0;
        mem_tryagain = 1'b0;
        #1 nub_reset = 1'b1;
        repeat (3) tick();
        check_reset_outputs("por");
        nub_reset = 1'b0;
        tick();

        for (int i = 0; i < 17; i++) run_txn(vecs[i]);

        // Miss: slot space but another card's ID
        cur_resp = R_RDY;
        cur_wait = 0;
        start_pulse(32'hF500_0000, 1'b1, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (mem_valid || tgt_busy) seen = 1'b1;
            tick();
        end
        chk("miss_ignored", {31'd0, seen}, 32'd0);

        // Second START while the first transfer waits in MEM
        v = '{32'hF900_0200, 1'b1, 1'b0, 32'hCAFE_F00D, 6, R_RDY, 32'hF900_0200, 4'b0000, 2'b00};
        cur_wait  = v.wt;
        cur_resp  = v.resp;
        cur_rdata = v.data;
        base      = ack_count;
        start_pulse(v.ad, v.tm1n, v.tm0n);
        push_exp(v, 2 + v.wt);
        exp_acks++;
        wait_valid();
        tick();
        start_pulse(32'hF900_0300, 1'b0, 1'b0);
        wait_ack();
        repeat (12) tick();
        chk("busy_start_single_ack", ack_count - base, 32'd1);

        // Reset while a write sits in MEM with no memory response
        v = '{32'h9000_0008, 1'b0, 1'b0, 32'h7777_1234, 0, R_NONE, 32'h9000_0008, 4'b0011, 2'b10};
        cur_wait  = 0;
        cur_resp  = R_NONE;
        cur_rdata = v.data;
        base      = ack_count;
        start_pulse(v.ad, v.tm1n, v.tm0n);
        push_exp(v, 17);
        nub_adn_i = ~v.data;
        tick();
        nub_adn_i = '1;
        wait_valid();
        chk("mid_wdata_before_reset", mem_wdata, 32'h7777_1234);
        repeat (3) tick();
        #2 nub_reset = 1'b1;
        #1;
        check_reset_outputs("mid");
        exp_q.delete();
        tick();
        tick();
        nub_reset = 1'b0;
        repeat (25) tick();
        chk("no_ack_after_reset", ack_count - base, 32'd0);

        // Target still usable after the abandoned transfer
        run_txn(vecs[0]);

        chk("ack_total", ack_count, exp_acks);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
